fifo_uart_tx: RTL and testbench

// - Read side of the sample FIFO: drains bytes from the FIFO read port and serialises them as UART 8N1 for the host link.
// - Sits between the FIFO (read_en / d_out / isEmpty) and the board TX pin.
// - Reads one byte only when the FIFO is non-empty and the block is enabled.
// - Frames each byte; back-to-back frames are sent while data remains.

---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 tb/tb_fifo_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and line constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic        TX_IDLE   = 1'b1;
    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick marks the last cycle of a bit, pre_tick the cycle before it.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] NEAR = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = (cnt == LAST);
    assign pre_tick = (cnt == NEAR);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the sample FIFO and sends each one as a UART 8N1 frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_isEmpty,
    input  logic [DATA_W-1:0] fifo_d_out,
    output logic              fifo_read_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [1:0]        wait_cnt, wait_n;
    logic              tx_n, read_en_n, busy_n, byte_done_n;
    logic              tick, pre_tick, baud_clear;

    // Holding the counter clear outside the frame aligns bit periods to START entry.
    assign baud_clear = !(state inside {START, DATA, STOP});

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (sys_clock),
        .rst_n   (reset),
        .clear   (baud_clear),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        wait_n  = wait_cnt;
        case (state)
            IDLE:  if (enable && !fifo_isEmpty) state_n = FETCH;
            FETCH: begin
                state_n = WAIT;
                wait_n  = '0;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    shift_n = fifo_d_out;
                    state_n = START;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_LAST) state_n = STOP;
                    else                     bit_n   = bit_cnt + 1'b1;
                end
            end
            STOP:    if (tick) state_n = (enable && !fifo_isEmpty) ? FETCH : IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are computed from next-state values so the registers line up with the state.
        read_en_n   = (state_n == FETCH);
        busy_n      = (state_n != IDLE);
        byte_done_n = (state == STOP) && pre_tick;
        case (state_n)
            START:   tx_n = ~TX_IDLE;
            DATA:    tx_n = shift_n[0];
            default: tx_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            tx           <= TX_IDLE;
            fifo_read_en <= 1'b0;
            busy         <= 1'b0;
            byte_done    <= 1'b0;
        end else begin
            state        <= state_n;
            shift        <= shift_n;
            bit_cnt      <= bit_n;
            wait_cnt     <= wait_n;
            tx           <= tx_n;
            fifo_read_en <= read_en_n;
            busy         <= busy_n;
            byte_done    <= byte_done_n;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, scoreboard of pushed bytes, frame-level line decoder.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int RLAT  = 1;
    localparam int FRAME = 10 * CPB;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_isEmpty;
    logic [7:0] fifo_d_out = 8'h00;
    logic       fifo_read_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    int checks = 0;
    int errors = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .READ_LAT    (RLAT),
        .DATA_W      (8)
    ) dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .enable      (enable),
        .fifo_isEmpty(fifo_isEmpty),
        .fifo_d_out  (fifo_d_out),
        .fifo_read_en(fifo_read_en),
        .tx          (tx),
        .busy        (busy),
        .byte_done   (byte_done)
    );

    always #5 sys_clock = ~sys_clock;

    // FIFO model: one-cycle read latency, pops on each sampled read_en
    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] exp_q [$];

    assign fifo_isEmpty = (rd_ptr == wr_ptr);

    always @(posedge sys_clock) begin
        if (fifo_read_en && rd_ptr != wr_ptr) begin
            fifo_d_out <= mem[rd_ptr % 64];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    int   rd_pulses = 0;
    int   rd_long   = 0;
    logic rd_prev   = 1'b0;
    always @(negedge sys_clock) begin
        if (fifo_read_en === 1'b1) rd_pulses++;
        if (fifo_read_en === 1'b1 && rd_prev) rd_long++;
        rd_prev = (fifo_read_en === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    // Waits for a start bit, then samples one whole frame against the next expected byte.
    task automatic recv_frame(input int drop_at, input int abort_at, output int gap);
        logic [FRAME-1:0] tx_v, tx_e, bd_v, bd_e, busy_v;
        logic [7:0] exp_b, sh, dec;
        logic       e;
        gap    = 0;
        tx_v   = '0;
        tx_e   = '0;
        bd_v   = '0;
        busy_v = '0;
        dec    = '0;
        @(negedge sys_clock);
        while (tx === 1'b1 && gap < 400) begin
            gap++;
            @(negedge sys_clock);
        end
        if (tx !== 1'b0) begin
            check("start_found", 64'(tx), 64'(0));
            return;
        end
        check("frame_expected", 64'(exp_q.size() != 0), 64'(1));
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        sh    = exp_b;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge sys_clock);
            if (i < CPB)          e = 1'b0;
            else if (i < 9 * CPB) e = sh[0];
            else                  e = 1'b1;
            tx_v   = {tx, tx_v[FRAME-1:1]};
            tx_e   = {e, tx_e[FRAME-1:1]};
            bd_v   = {byte_done, bd_v[FRAME-1:1]};
            busy_v = {busy, busy_v[FRAME-1:1]};
            if (i >= CPB && i < 9 * CPB) begin
                if ((i - CPB) % CPB == CPB / 2) dec = {tx, dec[7:1]};
                if ((i - CPB) % CPB == CPB - 1) sh = sh >> 1;
            end
            if (i == drop_at) enable = 1'b0;
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_tx", 64'(tx), 64'(1));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_rd_en", 64'(fifo_read_en), 64'(0));
                return;
            end
        end
        bd_e = '0;
        bd_e[FRAME-1] = 1'b1;
        check("frame_tx", 64'(tx_v), 64'(tx_e));
        check("byte", 64'(dec), 64'(exp_b));
        check("byte_done", 64'(bd_v), 64'(bd_e));
        check("busy_frame", 64'(busy_v), {{(64-FRAME){1'b0}}, {FRAME{1'b1}}});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int gap;
        int base;
        int n;
        int bad_tx, bad_rd, bad_busy;
        reset  = 1'b1;
        enable = 1'b1;
        #2 reset = 1'b0;

        // Reset held with a byte waiting
        push(8'h01);
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clock);
            check("rst_tx", 64'(tx), 64'(1));
            check("rst_rd_en", 64'(fifo_read_en), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_byte_done", 64'(byte_done), 64'(0));
        end

        // Single byte after release
        reset = 1'b1;
        recv_frame(-1, -1, gap);
        check("single_rd_pulses", 64'(rd_pulses), 64'(1));
        repeat (10) @(negedge sys_clock);
        check("single_idle_busy", 64'(busy), 64'(0));
        check("single_idle_tx", 64'(tx), 64'(1));
        check("single_rd_after", 64'(rd_pulses), 64'(1));

        // Three back-to-back frames
        base = rd_pulses;
        push(8'h01);
        push(8'h00);
        push(8'h03);
        for (int j = 0; j < 3; j++) begin
            recv_frame(-1, -1, gap);
            if (j > 0) check("burst3_gap", 64'(gap), 64'(1 + RLAT));
        end
        repeat (4) @(negedge sys_clock);
        check("burst3_rd_pulses", 64'(rd_pulses - base), 64'(3));

        // Random bursts
        for (int r = 0; r < 4; r++) begin
            base = rd_pulses;
            n = int'($urandom_range(2, 5));
            for (int j = 0; j < n; j++) push(8'($urandom));
            for (int j = 0; j < n; j++) begin
                recv_frame(-1, -1, gap);
                if (j > 0) check("rand_gap", 64'(gap), 64'(1 + RLAT));
            end
            repeat (int'($urandom_range(3, 12))) @(negedge sys_clock);
            check("rand_rd_pulses", 64'(rd_pulses - base), 64'(n));
            check("rand_idle_busy", 64'(busy), 64'(0));
        end

        // Empty FIFO with enable high
        base     = rd_pulses;
        bad_tx   = 0;
        bad_rd   = 0;
        bad_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clock);
            if (tx !== 1'b1) bad_tx++;
            if (fifo_read_en !== 1'b0) bad_rd++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("empty_tx_low_cycles", 64'(bad_tx), 64'(0));
        check("empty_rd_cycles", 64'(bad_rd), 64'(0));
        check("empty_busy_cycles", 64'(bad_busy), 64'(0));
        check("empty_rd_pulses", 64'(rd_pulses - base), 64'(0));

        // Enable dropped during DATA of the first frame
        base = rd_pulses;
        push(8'hFF);
        push(8'h02);
        recv_frame(3 * CPB, -1, gap);
        bad_tx = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clock);
            if (tx !== 1'b1) bad_tx++;
        end
        check("drop_rd_pulses", 64'(rd_pulses - base), 64'(1));
        check("drop_tx_low_cycles", 64'(bad_tx), 64'(0));
        check("drop_busy", 64'(busy), 64'(0));
        enable = 1'b1;
        recv_frame(-1, -1, gap);
        check("drop_resume_rd_pulses", 64'(rd_pulses - base), 64'(2));

        // Reset in data bit 3 of 0xA5
        base = rd_pulses;
        push(8'hA5);
        recv_frame(-1, 4 * CPB + 1, gap);
        repeat (3) @(negedge sys_clock);
        reset = 1'b1;
        repeat (5) @(negedge sys_clock);
        check("post_rst_tx", 64'(tx), 64'(1));
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_rd_pulses", 64'(rd_pulses - base), 64'(1));
        push(8'h3C);
        recv_frame(-1, -1, gap);
        check("post_rst_frame_rd", 64'(rd_pulses - base), 64'(2));
        check("rd_en_width", 64'(rd_long), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
